fifo_wptr_full: RTL and testbench

Write-side pointer and full-flag generator for an asynchronous FIFO. It keeps a binary write pointer and its registered Gray-code image, and synchronizes the read-side Gray pointer into the write clock domain. It compares the two pointers to produce a registered full flag. Its Gray pointer output crosses to the read domain, where the downstream Gray-to-binary stage consumes it.

---
 rtl/fifo_wptr_full_pkg.sv | 35 +++
 rtl/fifo_wptr_full_sync_2ff.sv | 40 ++++
 rtl/fifo_wptr_full.sv | 109 ++++++++++
 tb/tb_fifo_wptr_full.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wptr_full_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full_pkg
// Description : Shared definitions for the asynchronous FIFO pointer blocks.
//               Holds the default address width and the binary<->Gray
//               conversion helpers. The read-pointer block imports the same
//               package so that both domains encode pointers identically.
// Contents    : DEFAULT_ADDR_W   - default FIFO address width (depth 2^W)
//               bin2gray()       - binary to reflected Gray code
//               gray2bin()       - reflected Gray code to binary
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_wptr_full_pkg;

    localparam int DEFAULT_ADDR_W = 4;

    // Helpers work on a 32-bit container; callers zero-extend their pointer
    // in and truncate the result back. Zero upper bits do not disturb either
    // conversion, so any pointer width up to 32 is handled.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_wptr_full_pkg
`default_nettype wire

// File: rtl/fifo_wptr_full_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a multi-bit bus whose value changes
//               by at most one bit at a time (e.g. a Gray-coded pointer).
//               No logic is placed between the two stages so the first flop
//               has a full clock period to resolve metastability.
// Parameters  : WIDTH  - bus width
// Ports       : clk    in  - destination-domain clock
//               rst_n  in  - asynchronous active-low reset, clears to 0
//               d      in  [WIDTH] - asynchronous input bus
//               q      out [WIDTH] - synchronized bus (2-edge latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= d;
            r_q2 <= r_q1;
        end
    end

    assign q = r_q2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full
// Description : Write-side pointer and full-flag generator of an asynchronous
//               FIFO. Keeps a binary write pointer plus its registered Gray
//               image, synchronizes the read-side Gray pointer into the write
//               clock domain and produces a registered, pessimistic full flag.
// Parameters  : ADDR_W          - FIFO address width, depth = 2^ADDR_W (>= 2)
// Ports       : clk             in  - write-domain clock
//               rst_n           in  - asynchronous active-low reset
//               winc            in  - write request
//               rptr_gray_async in  [ADDR_W+1] - read Gray pointer (async)
//               waddr           out [ADDR_W]   - RAM write address
//               wptr_gray       out [ADDR_W+1] - registered Gray write pointer
//               wfull           out - registered full flag
//               wlevel          out [ADDR_W+1] - write-side fill level
// Config      : FIFO_WLEVEL_EN  - when defined, wlevel carries the registered
//               fill level; otherwise wlevel is tied to 0 and no Gray-to-
//               binary logic is built.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wptr_full
    import fifo_wptr_full_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray_async,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
    output logic [ADDR_W:0]   wlevel
);

    localparam int c_PTR_W = ADDR_W + 1;

    logic [ADDR_W:0] r_wbin;
    logic [ADDR_W:0] r_wgray;
    logic            r_wfull;

    logic            w_wpush;
    logic [ADDR_W:0] w_wbin_next;
    logic [ADDR_W:0] w_wgray_next;
    logic [ADDR_W:0] w_rq2;
    logic [ADDR_W:0] w_full_ref;
    logic            w_wfull_next;

    // Read pointer into the write domain.
    sync_2ff #(
        .WIDTH (c_PTR_W)
    ) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rptr_gray_async),
        .q     (w_rq2)
    );

    assign w_wpush      = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + c_PTR_W'(w_wpush);
    assign w_wgray_next = c_PTR_W'(bin2gray(32'(w_wbin_next)));

    // In Gray code, "write pointer is exactly one lap ahead of read pointer"
    // means the top two bits differ and the rest match. A stale rq2 only
    // lags the real read pointer, so this can keep full set too long but
    // never clears it early.
    assign w_full_ref   = {~w_rq2[ADDR_W:ADDR_W-1], w_rq2[ADDR_W-2:0]};
    assign w_wfull_next = (w_wgray_next == w_full_ref);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_wfull <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_wfull <= w_wfull_next;
        end
    end

`ifdef FIFO_WLEVEL_EN
    logic [ADDR_W:0] w_rbin;
    logic [ADDR_W:0] r_wlevel;

    // Same timing as wfull: computed from the post-push pointer and the
    // current synchronized read pointer. Modular subtraction absorbs wrap.
    assign w_rbin = c_PTR_W'(gray2bin(32'(w_rq2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wlevel <= '0;
        end else begin
            r_wlevel <= w_wbin_next - w_rbin;
        end
    end

    assign wlevel = r_wlevel;
`else
    assign wlevel = '0;
`endif

    assign waddr     = r_wbin[ADDR_W-1:0];
    assign wptr_gray = r_wgray;
    assign wfull     = r_wfull;

endmodule : fifo_wptr_full
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wptr_full
// Description : Self-checking bench for fifo_wptr_full (ADDR_W = 4).
//               A behavioural reference predicts the outputs of every clock
//               edge; predictions are queued when inputs are driven and
//               compared after the edge. Directed checks cover reset, fill,
//               drain-while-full, Gray wrap-around, async mid-run reset and
//               (with FIFO_WLEVEL_EN) the fill level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_full;

    localparam int c_AW = 4;
    localparam int c_PW = c_AW + 1;

    logic            clk;
    logic            rst_n;
    logic            winc;
    logic [c_AW:0]   rptr_gray_async;
    logic [c_AW-1:0] waddr;
    logic [c_AW:0]   wptr_gray;
    logic            wfull;
    logic [c_AW:0]   wlevel;

    fifo_wptr_full #(
        .ADDR_W (c_AW)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .winc            (winc),
        .rptr_gray_async (rptr_gray_async),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .wfull           (wfull),
        .wlevel          (wlevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_AW-1:0] waddr;
        logic [c_AW:0]   gray;
        logic            full;
        logic [c_AW:0]   level;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [c_AW:0] m_bin;
    logic [c_AW:0] m_rq1;
    logic [c_AW:0] m_rq2;
    logic          m_full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_AW:0] gray_of(input logic [c_AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [c_AW:0] bin_of(input logic [c_AW:0] g);
        logic [c_AW:0] b;
        b[c_AW] = g[c_AW];
        for (int i = c_AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset();
        m_bin  = '0;
        m_rq1  = '0;
        m_rq2  = '0;
        m_full = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then check.
    task automatic step(input logic inc, input logic [c_AW:0] rp);
        exp_t          e;
        exp_t          got;
        logic [c_AW:0] bn;
        logic [c_AW:0] lvl;
        winc            = inc;
        rptr_gray_async = rp;
        bn  = m_bin + c_PW'(inc & ~m_full);
        lvl = bn - bin_of(m_rq2);
        e.waddr = bn[c_AW-1:0];
        e.gray  = gray_of(bn);
        // Full means the writer is a whole FIFO depth ahead of the reader.
        e.full  = (lvl == c_PW'(1 << c_AW));
`ifdef FIFO_WLEVEL_EN
        e.level = lvl;
`else
        e.level = '0;
`endif
        exp_q.push_back(e);
        m_full = e.full;
        m_bin  = bn;
        m_rq2  = m_rq1;
        m_rq1  = rp;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check("waddr", waddr, got.waddr);
            check("wptr_gray", wptr_gray, got.gray);
            check("wfull", wfull, got.full);
            check("wlevel", wlevel, got.level);
        end
    endtask

    // Called about 1 time unit after an edge; reset pulses entirely between edges.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wptr_gray"}, wptr_gray, 0);
        check({tag, "_wfull"}, wfull, 0);
        check({tag, "_wlevel"}, wlevel, 0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_AW:0] prev_g;
        logic [c_AW:0] rd_bin;

        // ---------------- reset held with active inputs ----------------
        rst_n           = 1'b0;
        winc            = 1'b1;
        rptr_gray_async = 5'b10101;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_waddr", waddr, 0);
        check("rst_wptr_gray", wptr_gray, 0);
        check("rst_wfull", wfull, 0);
        check("rst_wlevel", wlevel, 0);
        #1 rst_n = 1'b1;

        step(1'b1, 5'b10101);
        check("first_push_waddr", waddr, 1);
        check("first_push_gray", wptr_gray, 5'b00001);

        // ---------------- mid-operation asynchronous reset ----------------
        repeat (8) step(1'b1, 5'b00000);
        check("nine_push_waddr", waddr, 9);
        async_reset("midrst");

        // ---------------- fill after reset ----------------
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 5'b00000);
            if (k == 15) check("fill_not_full_15", wfull, 0);
        end
        check("fill_full", wfull, 1);
        check("fill_gray", wptr_gray, 5'b11000);
        check("fill_waddr", waddr, 0);
        step(1'b1, 5'b00000);
        check("blocked_gray", wptr_gray, 5'b11000);
        check("blocked_waddr", waddr, 0);
        check("blocked_full", wfull, 1);

        // ---------------- drain while full ----------------
        step(1'b0, 5'b00001);
        check("drain_edge1_full", wfull, 1);
        step(1'b0, 5'b00001);
        check("drain_edge2_full", wfull, 1);
        step(1'b0, 5'b00001);
        check("drain_edge3_full", wfull, 0);
        step(1'b1, 5'b00001);
        check("refill_gray", wptr_gray, 5'b11001);
        check("refill_full", wfull, 1);

        // ---------------- wrap-around with reader in lockstep ----------------
        async_reset("wraprst");
        prev_g = wptr_gray;
        for (int k = 0; k < 32; k++) begin
            step(1'b1, gray_of(c_PW'(k)));
            check("wrap_one_bit", $countones(wptr_gray ^ prev_g), 1);
            prev_g = wptr_gray;
        end
        check("wrap_gray_zero", wptr_gray, 0);
        check("wrap_not_full", wfull, 0);

`ifdef FIFO_WLEVEL_EN
        // ---------------- fill level ----------------
        async_reset("lvlrst");
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 5'b00000);
            check("level_ramp", wlevel, k);
        end
        step(1'b0, 5'b00011);
        step(1'b0, 5'b00011);
        check("level_before_lag", wlevel, 5);
        step(1'b0, 5'b00011);
        check("level_after_read", wlevel, 3);
`endif

        // ---------------- random traffic with a legal reader ----------------
        async_reset("rndrst");
        rd_bin = '0;
        for (int k = 0; k < 300; k++) begin
            if ((m_bin != rd_bin) && ($urandom_range(1, 0) == 1)) rd_bin = rd_bin + 1'b1;
            step(1'($urandom_range(1, 0)), gray_of(rd_bin));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_wptr_full
`default_nettype wire
